frame_buffer_core: RTL and testbench



---
 rtl/fb_pkg.sv | 33 +++
 rtl/fb_ram.sv | 32 +++
 rtl/frame_buffer_core.sv | 188 ++++++++++++++++++
 tb/tb_frame_buffer_core.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer core.
//   wr_state_t    : states of the rx packet parser
//   DBG_*         : bit positions inside the debug status byte
//   HDR_BYTES     : number of address bytes that lead every screen packet
//   state_class() : collapses parser states into the 2-bit debug class
package fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_PIX_R,
    ST_PIX_G,
    ST_PIX_B,
    ST_DROP
  } wr_state_t;

  localparam int DBG_CLASS_LSB = 0;
  localparam int DBG_ERR_BIT   = 2;
  localparam int DBG_FEN_BIT   = 3;
  localparam int DBG_CNT_LSB   = 4;

  localparam int HDR_BYTES = 2;

  function automatic logic [1:0] state_class(input wr_state_t s);
    case (s)
      ST_IDLE:    return 2'd0;
      ST_ADDR_LO: return 2'd1;
      ST_DROP:    return 2'd3;
      default:    return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame RAM, one clock.
//   clk           : clock for both ports
//   we/wr_addr/wr_data : write port
//   re/rd_addr    : read request; rd_data valid the cycle after re
//   rd_data       : registered read data; a read of the address being
//                   written in the same cycle returns the old contents
module fb_ram
  import fb_pkg::*;
#(
  parameter int DEPTH  = 3072,
  parameter int AW     = 12,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments, so a same-address
  // read sees the value held before this edge's write.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_buffer_core.sv
// Frame store between the rx byte stream and the video timing generator.
// Screen packets (addr hi, addr lo, then R,G,B triplets) are written into
// an internal frame RAM; pixels are streamed out one per pixel_clock edge.
//   clk125        : sole clock
//   reset         : asynchronous, active-high
//   new_frame     : restart the read pointer at pixel 0
//   frame_enable  : 1 = stream pixels, 0 = R/G/B held at 0
//   pixel_clock   : asynchronous pixel strobe, one pixel per rising edge
//   screen_packet : frames a screen packet on the rx stream
//   rx_valid/rx_data : received byte stream
//   R/G/B         : pixel output
//   debug         : {packet_count, frame_enable, error, state class}
module frame_buffer_core
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 48,
  parameter int FB_DEPTH  = FB_WIDTH * FB_HEIGHT
) (
  input  logic       clk125,
  input  logic       reset,
  input  logic       new_frame,
  input  logic       frame_enable,
  input  logic       pixel_clock,
  input  logic       screen_packet,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic [7:0] debug
);

  localparam int AW = $clog2(FB_DEPTH);

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(FB_DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  wr_state_t     state, state_nxt;
  logic          err;
  logic [3:0]    pkt_cnt;
  logic [7:0]    addr_hi;
  logic [AW-1:0] wr_addr;
  logic [7:0]    pix_r, pix_g;
  logic          cap_hi, load_addr, cap_r, cap_g, we, set_err, cnt_inc;

  // Packet parser: next state and strobes.
  always_comb begin
    state_nxt = state;
    cap_hi    = 1'b0;
    load_addr = 1'b0;
    cap_r     = 1'b0;
    cap_g     = 1'b0;
    we        = 1'b0;
    set_err   = 1'b0;
    cnt_inc   = 1'b0;
    if (!screen_packet) begin
      state_nxt = ST_IDLE;
      // Leaving on a triplet boundary is a clean packet end; anywhere
      // else the packet was truncated and the partial triplet is lost.
      case (state)
        ST_ADDR_LO, ST_PIX_G, ST_PIX_B: set_err = 1'b1;
        ST_PIX_R:                       cnt_inc = 1'b1;
        default: ;
      endcase
    end else if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          cap_hi    = 1'b1;
          state_nxt = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          if ({addr_hi, rx_data} >= 16'(FB_DEPTH)) begin
            set_err   = 1'b1;
            state_nxt = ST_DROP;
          end else begin
            load_addr = 1'b1;
            state_nxt = ST_PIX_R;
          end
        end
        ST_PIX_R: begin
          cap_r     = 1'b1;
          state_nxt = ST_PIX_G;
        end
        ST_PIX_G: begin
          cap_g     = 1'b1;
          state_nxt = ST_PIX_B;
        end
        ST_PIX_B: begin
          we        = 1'b1;
          state_nxt = ST_PIX_R;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      err     <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (set_err) err <= 1'b1;
      if (cnt_inc) pkt_cnt <= pkt_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk125) begin
    if (cap_hi) addr_hi <= rx_data;
    if (cap_r)  pix_r   <= rx_data;
    if (cap_g)  pix_g   <= rx_data;
    if (load_addr)
      wr_addr <= AW'({addr_hi, rx_data});
    else if (we)
      wr_addr <= next_addr(wr_addr);
  end

  // Read side, stage p0: pixel_clock synchronizer and edge detect.
  logic          sync_p0, sync_p1, sync_p2;
  logic          strobe_p0, rd_en_p0;
  logic [AW-1:0] rd_addr;

  assign strobe_p0 = sync_p1 & ~sync_p2;
  assign rd_en_p0  = strobe_p0 & frame_enable & ~new_frame;

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      rd_addr <= '0;
    end else begin
      sync_p0 <= pixel_clock;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      if (new_frame)
        rd_addr <= '0;
      else if (rd_en_p0)
        rd_addr <= next_addr(rd_addr);
    end
  end

  // Stage p1: synchronous RAM read.
  logic [23:0] rd_data_p1;
  logic        vld_p1;

  fb_ram #(
    .DEPTH  (FB_DEPTH),
    .AW     (AW),
    .DATA_W (24)
  ) u_ram (
    .clk     (clk125),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data ({pix_r, pix_g, rx_data}),
    .re      (rd_en_p0),
    .rd_addr (rd_addr),
    .rd_data (rd_data_p1)
  );

  // Stage p2: output register.
  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      R      <= '0;
      G      <= '0;
      B      <= '0;
    end else begin
      vld_p1 <= rd_en_p0;
      if (!frame_enable)
        {R, G, B} <= '0;
      else if (vld_p1)
        {R, G, B} <= rd_data_p1;
    end
  end

  always_comb begin
    debug                        = '0;
    debug[DBG_CLASS_LSB +: 2]    = state_class(state);
    debug[DBG_ERR_BIT]           = err;
    debug[DBG_FEN_BIT]           = frame_enable;
    debug[DBG_CNT_LSB +: 4]      = pkt_cnt;
  end

endmodule

// File: tb/tb_frame_buffer_core.sv
module tb_frame_buffer_core;

  localparam int W     = 64;
  localparam int H     = 48;
  localparam int DEPTH = W * H;

  logic       clk125 = 1'b0;
  logic       reset, new_frame, frame_enable, pixel_clock;
  logic       screen_packet, rx_valid;
  logic [7:0] rx_data;
  logic [7:0] R, G, B, debug;

  always #4 clk125 = ~clk125;

  frame_buffer_core #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk125        (clk125),
    .reset         (reset),
    .new_frame     (new_frame),
    .frame_enable  (frame_enable),
    .pixel_clock   (pixel_clock),
    .screen_packet (screen_packet),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .R             (R),
    .G             (G),
    .B             (B),
    .debug         (debug)
  );

  // Reference model: frame contents as an array, plus packet-level state.
  logic [23:0] mem_m [DEPTH];
  bit          known [DEPTH];
  int          rd_ptr;
  logic        err_m;
  logic [3:0]  cnt_m;
  logic [23:0] pq [$];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dbg(input string tag, input logic [1:0] cls);
    check(tag, {24'd0, debug}, {24'd0, cnt_m, frame_enable, err_m, cls});
  endtask

  task automatic put_byte(input logic [7:0] b);
    screen_packet = 1'b1;
    rx_valid      = 1'b1;
    rx_data       = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // A valid-flagged garbage byte rides along the falling screen_packet.
  task automatic end_packet();
    screen_packet = 1'b0;
    rx_valid      = 1'b1;
    rx_data       = 8'($urandom);
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  // Sends pq as the pixel payload. extra: 0 = clean end, 1/2 = that many
  // bytes of an unfinished triplet, 3 = packet ends after the high address byte.
  task automatic send_packet(input logic [15:0] addr, input int extra);
    int a;
    put_byte(addr[15:8]);
    if (extra == 3) begin
      end_packet();
      err_m = 1'b1;
      return;
    end
    put_byte(addr[7:0]);
    a = int'(addr);
    for (int i = 0; i < pq.size(); i++) begin
      put_byte(pq[i][23:16]);
      put_byte(pq[i][15:8]);
      put_byte(pq[i][7:0]);
      mem_m[a] = pq[i];
      known[a] = 1'b1;
      a = (a + 1) % DEPTH;
    end
    for (int j = 0; j < extra; j++) put_byte(8'($urandom));
    end_packet();
    if (extra == 0) cnt_m = cnt_m + 4'd1;
    else            err_m = 1'b1;
  endtask

  task automatic pulse_new_frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    rd_ptr    = 0;
  endtask

  task automatic read_pixel(input string tag);
    pixel_clock = 1'b1;
    repeat (5) tick();
    if (!frame_enable) begin
      check(tag, {8'd0, R, G, B}, 32'd0);
    end else begin
      if (known[rd_ptr]) check(tag, {8'd0, R, G, B}, {8'd0, mem_m[rd_ptr]});
      rd_ptr = (rd_ptr + 1) % DEPTH;
    end
    pixel_clock = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; new_frame = 1'b0; frame_enable = 1'b0; pixel_clock = 1'b0;
    screen_packet = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    rd_ptr = 0; err_m = 1'b0; cnt_m = 4'd0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // Reset and idle
    tick();
    check("reset_rgb", {8'd0, R, G, B}, 32'd0);
    check_dbg("reset_debug", 2'd0);
    tick();
    reset = 1'b0;
    tick();
    read_pixel("disabled_pixel");
    check_dbg("idle_debug", 2'd0);

    // Basic packet at address 0
    pq = {};
    pq.push_back(24'h112233);
    pq.push_back(24'h445566);
    send_packet(16'h0000, 0);
    check_dbg("after_pkt1", 2'd0);
    frame_enable = 1'b1;
    pulse_new_frame();
    read_pixel("pkt1_px0");
    read_pixel("pkt1_px1");
    check_dbg("pkt1_debug", 2'd0);

    // Write address wraps from the last word to 0
    pq = {};
    pq.push_back(24'hAABBCC);
    pq.push_back(24'hDDEEFF);
    send_packet(16'(DEPTH - 1), 0);
    pulse_new_frame();
    read_pixel("wrap_px0");
    check_dbg("wrap_debug", 2'd0);

    // Packet cut short after R,G of a triplet
    pq = {};
    pq.push_back(24'h123456);
    send_packet(16'h0005, 2);
    check_dbg("short_pkt_debug", 2'd0);

    // new_frame coinciding with a pixel strobe
    pulse_new_frame();
    read_pixel("nf_px0");
    read_pixel("nf_px1");
    pixel_clock = 1'b1;
    tick();
    tick();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    rd_ptr    = 0;
    repeat (3) tick();
    check("nf_hold_rgb", {8'd0, R, G, B}, {8'd0, mem_m[1]});
    pixel_clock = 1'b0;
    repeat (3) tick();
    read_pixel("nf_after_px0");

    // frame_enable low forces zero output and freezes the read pointer
    frame_enable = 1'b0;
    tick();
    check("fen_off_rgb", {8'd0, R, G, B}, 32'd0);
    check_dbg("fen_off_debug", 2'd0);
    read_pixel("fen_off_pixel");
    frame_enable = 1'b1;
    read_pixel("fen_on_pixel");

    // Randomized packets, then read back the start of the frame
    for (int p = 0; p < 10; p++) begin
      int n, ex;
      pq = {};
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) pq.push_back(24'($urandom));
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      send_packet(16'($urandom_range(0, 40)), ex);
    end
    check_dbg("rand_debug", 2'd0);
    pulse_new_frame();
    for (int i = 0; i < 48; i++) read_pixel($sformatf("rand_px%0d", i));

    // Out-of-range start address
    put_byte(8'h0C);
    put_byte(8'h00);
    err_m = 1'b1;
    check_dbg("bad_addr_drop", 2'd3);
    put_byte(8'h99);
    put_byte(8'h77);
    check_dbg("bad_addr_drop2", 2'd3);
    end_packet();
    check_dbg("bad_addr_idle", 2'd0);
    pulse_new_frame();
    read_pixel("bad_addr_px0");

    // Asynchronous reset in the middle of a triplet
    put_byte(8'h00);
    put_byte(8'h00);
    put_byte(8'h5A);
    put_byte(8'hA5);
    #1;
    reset = 1'b1;
    #1;
    err_m  = 1'b0;
    cnt_m  = 4'd0;
    rd_ptr = 0;
    check("async_reset_rgb", {8'd0, R, G, B}, 32'd0);
    check_dbg("async_reset_debug", 2'd0);
    screen_packet = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    read_pixel("after_reset_px0");
    check_dbg("after_reset_debug", 2'd0);

    // Clean packet after reset counts from zero
    pq = {};
    pq.push_back(24'($urandom));
    send_packet(16'h0007, 0);
    check_dbg("post_reset_pkt", 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
